// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential RISC-V fetch front end (PC, imem request/response, field decode).
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned branch/jump targets trap into a sticky FAULT state.
`default_nettype none

module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic            op5,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     instr_count,
  output logic            fault
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;
`endif

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [31:0]     count_q;
  logic            req_valid_q;
  logic            instr_valid_q;
  logic            fault_q;

  logic [XLEN-1:0] pc_plus4_d;
  logic [XLEN-1:0] pc_next_d;
  logic            misalign_d;

  assign pc_plus4_d = pc_q + XLEN'(4);

  always_comb begin
    pc_next_d  = pc_plus4_d;
    misalign_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    if (pc_src) begin
      pc_next_d  = pc_target;
      misalign_d = (pc_target[1:0] != 2'b00);
    end
`else
    // Without the check, low target bits are silently dropped.
    if (pc_src) begin
      pc_next_d = pc_target & ~XLEN'(3);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      count_q       <= '0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          // The request valid is raised one cycle after entry from reset.
          if (req_valid_q && imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q       <= imem_rsp_data;
            instr_valid_q <= 1'b1;
            state_q       <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            count_q       <= count_q + 32'd1;
            instr_valid_q <= 1'b0;
            pc_q          <= pc_next_d;
            if (misalign_d) begin
              fault_q <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
              state_q <= S_FAULT;
`endif
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        S_FAULT: begin
          fault_q       <= 1'b1;
          req_valid_q   <= 1'b0;
          instr_valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_d;
  assign op             = instr_q[6:0];
  assign op5            = instr_q[5];
  assign funct3         = instr_q[14:12];
  assign funct7         = instr_q[30];
  assign rs1            = instr_q[19:15];
  assign rs2            = instr_q[24:20];
  assign rd             = instr_q[11:7];
  assign instr_count    = count_q;
  assign fault          = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  op;
  logic        op5;
  logic [2:0]  funct3;
  logic        funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] instr_count;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .op(op), .op5(op5), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .instr_count(instr_count), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // REQ -> WAIT -> VALID with a one-cycle response.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w);
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("imem_addr", imem_addr, a);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("req_dropped", {31'd0, imem_req_valid}, 32'd0);
    chk("wait_not_valid", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = w;
    tick();
    imem_rsp_valid = 1'b0;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, w);
    chk("pc", pc, a);
  endtask

  task automatic consume(input logic src, input logic [31:0] tgt);
    stall     = 1'b0;
    pc_src    = src;
    pc_target = tgt;
    tick();
    stall     = 1'b1;
    pc_src    = 1'b0;
    pc_target = 32'h0;
  endtask

  initial begin
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    stall = 1'b1; pc_src = 1'b0; pc_target = 32'h0;
    tick(); tick();

    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_op", {25'd0, op}, 32'h13);

    rst = 1'b1;
    tick();
    fetch(32'h0, 32'h0050_0093);
    chk("addi_op", {25'd0, op}, 32'h13);
    chk("addi_rd", {27'd0, rd}, 32'd1);
    chk("addi_funct3", {29'd0, funct3}, 32'd0);
    chk("addi_rs1", {27'd0, rs1}, 32'd0);
    chk("addi_rs2", {27'd0, rs2}, 32'd5);
    chk("addi_pc_plus4", pc_plus4, 32'd4);
    chk("count_before", instr_count, 32'd0);
    consume(1'b0, 32'h0);
    chk("count_after", instr_count, 32'd1);

    fetch(32'h4, 32'h0010_0113);
    consume(1'b0, 32'h0);
    fetch(32'h8, 32'h0020_0193);
    consume(1'b0, 32'h0);
    fetch(32'hC, 32'h0030_0213);
    consume(1'b0, 32'h0);
    chk("stream_count", instr_count, 32'd4);
    chk("stream_addr", imem_addr, 32'h10);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("held_addr", imem_addr, 32'h10);
    end
    fetch(32'h10, 32'h4020_8133);
    chk("sub_op", {25'd0, op}, 32'h33);
    chk("sub_op5", {31'd0, op5}, 32'd1);
    chk("sub_funct7", {31'd0, funct7}, 32'd1);
    chk("sub_rs1", {27'd0, rs1}, 32'd1);
    chk("sub_rs2", {27'd0, rs2}, 32'd2);
    chk("sub_rd", {27'd0, rd}, 32'd2);
    pc_src = 1'b1; pc_target = 32'h0000_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h4020_8133);
      chk("stall_count", instr_count, 32'd4);
      chk("stall_pc", pc, 32'h10);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    consume(1'b1, 32'h0000_0100);
    chk("branch_addr", imem_addr, 32'h100);
    chk("branch_count", instr_count, 32'd5);

    fetch(32'h100, 32'h0000_006F);
    consume(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0013);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    consume(1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_count", instr_count, 32'd7);

    fetch(32'h0, 32'h0000_0063);
    consume(1'b1, 32'h0000_0102);
    chk("mis_count", instr_count, 32'd8);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_pc", pc, 32'h102);
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b1;
      tick();
      chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("fault_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("fault_sticky", {31'd0, fault}, 32'd1);
    end
    imem_req_ready = 1'b0;
`else
    chk("mis_fault", {31'd0, fault}, 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req", {31'd0, imem_req_valid}, 32'd1);
`endif

    // Asynchronous reset mid-cycle, then reset while waiting on a response.
    #2 rst = 1'b0;
    #1;
    chk("async_count", instr_count, 32'd0);
    chk("async_pc", pc, 32'd0);
    chk("async_fault", {31'd0, fault}, 32'd0);
    chk("async_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("refetch_req", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("in_wait", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    chk("rst_wait_req", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("stale_instr", instr, 32'h0000_0013);
    chk("stale_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_req", {31'd0, imem_req_valid}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0);
    imem_rsp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
